// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with optional first-word-fall-through output,
// occupancy count, programmable almost flags and overflow/underflow pulses.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          din,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (DATA_W < 1) begin : g_chk_width
    $error("sync_fifo_param: DATA_W must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("sync_fifo_param: DEPTH must be a power of two, 2 or greater");
  end
  if (AF_LEVEL > DEPTH) begin : g_chk_af
    $error("sync_fifo_param: AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_chk_ae
    $error("sync_fifo_param: AE_LEVEL must be below DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [CW-1:0]     count_nxt;

  // Stage p0: accept decisions and next occupancy from the registered state
  always_comb begin
    wr_acc    = wr_en & ~full;
    rd_acc    = rd_en & ~empty;
    count_nxt = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Stage p1: pointers, occupancy and flags registered from next-state count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    // Head entry shown combinationally; forced to zero while empty so reset reads 0
    assign dout = empty ? '0 : mem[rd_ptr];
  end else begin : g_std
    logic [DATA_W-1:0] dout_p1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_p1 <= '0;
      end else if (rd_acc) begin
        dout_p1 <= mem[rd_ptr];
      end
    end

    assign dout = dout_p1;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-read instance and an FWFT
// instance, checked against hand-computed values and a small queue model.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [7:0] f_din = '0;
  logic [7:0] f_dout;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en),
    .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
    .underflow(f_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] model_q[$];
  logic [7:0] last_dout;
  logic [7:0] exp_data;
  int         cnt_m;
  logic       w, r, ov_e, un_e, wa, ra;

  initial begin
    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    check("rst_ov", overflow, 0);
    check("rst_un", underflow, 0);
    check("rst_dout", dout, 0);
    check("f_rst_empty", f_empty, 1);

    // FWFT: write into empty, head appears without rd_en
    f_wr_en = 1'b1; f_din = 8'h3C;
    tick();
    f_wr_en = 1'b0;
    check("fwft_empty_fall", f_empty, 0);
    check("fwft_dout_3c", f_dout, 8'h3C);
    f_wr_en = 1'b1; f_din = 8'h4D;
    tick();
    f_wr_en = 1'b0;
    check("fwft_head_hold", f_dout, 8'h3C);
    check("fwft_count2", f_count, 2);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    check("fwft_next_4d", f_dout, 8'h4D);
    check("fwft_count1", f_count, 1);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    check("fwft_empty_rise", f_empty, 1);

    // Fill 0x01..0x10, almost_full rises after the 14th push
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = 8'(i + 1);
      tick();
      check($sformatf("fill_af_%0d", i + 1), almost_full, (i + 1 >= 14) ? 1 : 0);
    end
    wr_en = 1'b0;
    check("fill_full", full, 1);
    check("fill_count", count, 16);

    // Full: read accepted, write of 0xAA rejected
    wr_en = 1'b1; rd_en = 1'b1; din = 8'hAA;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("full_rw_dout", dout, 8'h01);
    check("full_rw_count", count, 15);
    check("full_rw_ov", overflow, 1);
    check("full_rw_notfull", full, 0);
    tick();
    check("ov_one_cycle", overflow, 0);

    // Drain 0x02..0x10, almost_empty once count reaches 2
    for (int i = 0; i < 15; i++) begin
      rd_en = 1'b1;
      tick();
      check($sformatf("drain_dout_%0d", i), dout, 8'(i + 2));
      check($sformatf("drain_ae_%0d", i), almost_empty, (14 - i <= 2) ? 1 : 0);
    end
    rd_en = 1'b0;
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);

    // Empty: rejected read
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_rd_un", underflow, 1);
    check("empty_rd_count", count, 0);
    check("empty_rd_dout_hold", dout, 8'h10);
    tick();
    check("un_one_cycle", underflow, 0);
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h55;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("empty_rw_count", count, 1);
    check("empty_rw_dout_hold", dout, 8'h10);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pop_55", dout, 8'h55);
    check("pop_55_empty", empty, 1);

    // Wrap: fill past full, then drain past empty, against a queue model
    last_dout = 8'h55;
    cnt_m = 0;
    for (int c = 0; c < 48; c++) begin
      w = (c < 24) ? 1'b1 : ((c % 4) == 0);
      r = (c < 24) ? ((c % 4) == 3) : 1'b1;
      wr_en = w; rd_en = r; din = 8'(c * 7 + 3);
      wa = w && (cnt_m < 16);
      ra = r && (cnt_m > 0);
      ov_e = w && (cnt_m == 16);
      un_e = r && (cnt_m == 0);
      if (ra) last_dout = model_q.pop_front();
      if (wa) model_q.push_back(8'(c * 7 + 3));
      cnt_m = cnt_m + (wa ? 1 : 0) - (ra ? 1 : 0);
      tick();
      check($sformatf("wrap_dout_%0d", c), dout, last_dout);
      check($sformatf("wrap_count_%0d", c), count, cnt_m);
      check($sformatf("wrap_ov_%0d", c), overflow, ov_e);
      check($sformatf("wrap_un_%0d", c), underflow, un_e);
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // Mid-stream reset discards contents immediately
    exp_data = 8'h11;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = 8'(8'h11 * (i + 1));
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    check("pre_rst_dout", dout, exp_data);
    rd_en = 1'b0; wr_en = 1'b1; din = 8'h99;
    rst_n = 1'b0;
    #2;
    check("async_rst_count", count, 0);
    check("async_rst_empty", empty, 1);
    check("async_rst_dout", dout, 0);
    check("async_rst_full", full, 0);
    wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
    wr_en = 1'b1; din = 8'h77;
    tick();
    wr_en = 1'b0;
    check("post_rst_count", count, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("post_rst_dout", dout, 8'h77);
    check("post_rst_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
